// File: rtl/fxp_pkg.sv
// Q-format constants and FSM encoding shared by the requantizer
// and the upstream Q1.0.7 + Q1.1.14 adder stage.
package fxp_pkg;

  localparam int NUM_LANES     = 32;
  localparam int IN_W          = 16;
  localparam int OUT_W         = 8;
  localparam int IN_FRAC       = 14;
  localparam int OUT_FRAC      = 7;
  localparam int FRAC_SHIFT    = IN_FRAC - OUT_FRAC;
  localparam int LANES_PER_CYC = 4;
  localparam int OUT_MAX       = 127;
  localparam int OUT_MIN       = -128;
  localparam int ROUND_BIAS    = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    FINISH  = 2'd2
  } state_t;

endpackage

// File: rtl/fxp_requant_lane.sv
// One lane Q1.1.14 -> Q1.0.7: round half up, then saturate.
// Purely combinational.
module fxp_requant_lane
  import fxp_pkg::*;
#(
  parameter int IN_W       = fxp_pkg::IN_W,
  parameter int OUT_W      = fxp_pkg::OUT_W,
  parameter int FRAC_SHIFT = fxp_pkg::FRAC_SHIFT
) (
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y,
  output logic             sat
);

  localparam int TW = IN_W + 1 - FRAC_SHIFT;
  localparam logic signed [TW-1:0] T_MAX = TW'(OUT_MAX);
  localparam logic signed [TW-1:0] T_MIN = TW'(OUT_MIN);

  logic signed [IN_W:0] sum;
  logic signed [TW-1:0] t;

  // one guard bit keeps 0x7FFF + bias from wrapping
  assign sum = $signed({x[IN_W-1], x})
             + $signed((IN_W+1)'(ROUND_BIAS));
  assign t   = sum[IN_W:FRAC_SHIFT];

  always_comb begin
    y   = t[OUT_W-1:0];
    sat = 1'b0;
    unique case (1'b1)
      (t > T_MAX): begin
        y   = OUT_W'(OUT_MAX);
        sat = 1'b1;
      end
      (t < T_MIN): begin
        y   = OUT_W'(OUT_MIN);
        sat = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fixed_point_requantizer.sv
// Narrows a Q1.1.14 vector to Q1.0.7, LANES_PER_CYC lanes per cycle,
// under a start/done handshake.
module fixed_point_requantizer
  import fxp_pkg::*;
#(
  parameter int NUM_LANES     = fxp_pkg::NUM_LANES,
  parameter int IN_W          = fxp_pkg::IN_W,
  parameter int OUT_W         = fxp_pkg::OUT_W,
  parameter int FRAC_SHIFT    = fxp_pkg::FRAC_SHIFT,
  parameter int LANES_PER_CYC = fxp_pkg::LANES_PER_CYC
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [NUM_LANES*IN_W-1:0]  nums1_1_14,
  output logic [NUM_LANES*OUT_W-1:0] nums1_0_7,
  output logic [NUM_LANES-1:0]       sat_flags,
  output logic [$clog2(NUM_LANES+1)-1:0] sat_count,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = $clog2(NUM_LANES);
  localparam int CNT_W = $clog2(NUM_LANES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_LANES - LANES_PER_CYC);
  localparam logic [IDX_W-1:0] STEP = IDX_W'(LANES_PER_CYC);

  state_t state, state_nx;

  logic [NUM_LANES-1:0][IN_W-1:0]  in_q;
  logic [NUM_LANES-1:0][OUT_W-1:0] work;
  logic [NUM_LANES-1:0]            work_flags;
  logic [IDX_W-1:0]                idx;
  logic [CNT_W-1:0]                pop;

  logic [LANES_PER_CYC-1:0][IDX_W-1:0] lane_idx;
  logic [LANES_PER_CYC-1:0][OUT_W-1:0] lane_y;
  logic [LANES_PER_CYC-1:0]            lane_sat;

  for (genvar g = 0; g < LANES_PER_CYC; g++) begin : g_lane
    assign lane_idx[g] = idx + IDX_W'(g);
    fxp_requant_lane #(
      .IN_W      (IN_W),
      .OUT_W     (OUT_W),
      .FRAC_SHIFT(FRAC_SHIFT)
    ) u_lane (
      .x  (in_q[lane_idx[g]]),
      .y  (lane_y[g]),
      .sat(lane_sat[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (ena) state_nx = CONVERT;
      CONVERT: if (idx == LAST_IDX) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_LANES; i++)
      pop = pop + CNT_W'(work_flags[i]);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q       <= '0;
      work       <= '0;
      work_flags <= '0;
      idx        <= '0;
      nums1_0_7  <= '0;
      sat_flags  <= '0;
      sat_count  <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ena) begin
            in_q       <= nums1_1_14;
            work       <= '0;
            work_flags <= '0;
            idx        <= '0;
          end
        end
        CONVERT: begin
          for (int g = 0; g < LANES_PER_CYC; g++) begin
            work[lane_idx[g]]       <= lane_y[g];
            work_flags[lane_idx[g]] <= lane_sat[g];
          end
          idx <= idx + STEP;
        end
        FINISH: begin
          nums1_0_7 <= work;
          sat_flags <= work_flags;
          sat_count <= pop;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_requantizer.sv
// Randomized bench for fixed_point_requantizer against a plain
// arithmetic model of round-half-up plus saturation.
module tb_fixed_point_requantizer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [511:0] nums;
  logic [255:0] q;
  logic [31:0]  sf;
  logic [5:0]   sc;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [255:0] exp_q;
  logic [31:0]  exp_f;
  logic [5:0]   exp_c;

  always #5 clk = ~clk;

  fixed_point_requantizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .nums1_1_14(nums),
    .nums1_0_7 (q),
    .sat_flags (sf),
    .sat_count (sc),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  function automatic void model(input  logic [511:0] v,
                                output logic [255:0] y,
                                output logic [31:0]  f,
                                output logic [5:0]   c);
    y = '0;
    f = '0;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      integer x, n, t;
      x = integer'($signed(v[i*16 +: 16]));
      n = x + 64;
      t = (n >= 0) ? n / 128 : -((127 - n) / 128);
      if (t > 127) begin
        y[i*8 +: 8] = 8'h7F;
        f[i] = 1'b1;
        c = c + 6'd1;
      end else if (t < -128) begin
        y[i*8 +: 8] = 8'h80;
        f[i] = 1'b1;
        c = c + 6'd1;
      end else begin
        y[i*8 +: 8] = 8'(t);
      end
    end
  endfunction

  function automatic logic [511:0] rand_vec(input int mode);
    logic [511:0] v;
    logic [15:0]  w;
    int           m;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      m = (mode < 0) ? int'($urandom_range(0, 3)) : mode;
      case (m)
        1: w = 16'($urandom_range(0, 511) * 128 + 63
                   + $urandom_range(0, 2));
        2: w = 16'(32'h3F80 + $urandom_range(0, 127));
        3: w = 16'(32'hBFC0 + $urandom_range(0, 128));
        default: w = 16'($urandom);
      endcase
      v[i*16 +: 16] = w;
    end
    return v;
  endfunction

  task automatic run_vec(input logic [511:0] v, input string tag);
    logic [255:0] ny;
    logic [31:0]  nf;
    logic [5:0]   nc;
    int           lat;
    model(v, ny, nf, nc);
    lat = -1;
    @(negedge clk);
    nums = v;
    ena  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ena  = 1'b0;
    nums = rand_vec(0);
    chk({tag, " busy"}, 256'(busy), 256'(1'b1));
    for (int k = 1; k <= 15 && lat < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      nums = rand_vec(0);
      if (k == 4) chk({tag, " hold"}, q, exp_q);
      if (done) lat = k;
    end
    chk({tag, " lat"}, 256'(lat), 256'(9));
    chk({tag, " q"}, q, ny);
    chk({tag, " flags"}, 256'(sf), 256'(nf));
    chk({tag, " cnt"}, 256'(sc), 256'(nc));
    chk({tag, " idle"}, 256'(busy), 256'(1'b0));
    @(posedge clk);
    @(negedge clk);
    chk({tag, " pulse"}, 256'(done), 256'(1'b0));
    exp_q = ny;
    exp_f = nf;
    exp_c = nc;
  endtask

  initial begin
    logic [511:0] v;
    logic [511:0] cap [$];
    int           dpos [$];
    int           ndone;
    logic [255:0] ny;
    logic [31:0]  nf;
    logic [5:0]   nc;

    rst_n = 1'b0;
    ena   = 1'b0;
    nums  = '0;
    exp_q = '0;
    exp_f = '0;
    exp_c = '0;
    @(negedge clk);
    chk("rst q", q, '0);
    chk("rst flags", 256'(sf), '0);
    chk("rst cnt", 256'(sc), '0);
    chk("rst busy", 256'(busy), '0);
    chk("rst done", 256'(done), '0);
    rst_n = 1'b1;

    v = '0;
    v[0*16 +: 16] = 16'h0040;
    v[1*16 +: 16] = 16'h003F;
    v[2*16 +: 16] = 16'hFFC0;
    v[3*16 +: 16] = 16'hFFBF;
    run_vec(v, "round");
    chk("round lanes", 256'(q[31:0]), 256'(32'hFF000001));

    v = '0;
    v[0*16 +: 16] = 16'h2000;
    v[1*16 +: 16] = 16'hE000;
    v[2*16 +: 16] = 16'hC000;
    v[3*16 +: 16] = 16'h8000;
    v[4*16 +: 16] = 16'h7FFF;
    run_vec(v, "exact");
    chk("exact cnt2", 256'(sc), 256'(6'd2));

    v = {32{16'h4000}};
    run_vec(v, "fullsat");
    chk("fullsat flags", 256'(sf), 256'(32'hFFFFFFFF));

    v = {32{16'h3000}};
    run_vec(v, "chain");
    chk("chain q", q, {32{8'h60}});

    for (int r = 0; r < 16; r++)
      run_vec(rand_vec(r < 4 ? r : -1), $sformatf("rnd%0d", r));

    // ena held high with a changing input
    ndone = 0;
    for (int e = 0; e < 30; e++) begin
      nums = rand_vec(-1);
      ena  = 1'b1;
      if (e % 10 == 0) cap.push_back(nums);
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        dpos.push_back(e);
        if (ndone < cap.size()) begin
          model(cap[ndone], ny, nf, nc);
          chk($sformatf("hs%0d q", ndone), q, ny);
          chk($sformatf("hs%0d flags", ndone), 256'(sf), 256'(nf));
          chk($sformatf("hs%0d cnt", ndone), 256'(sc), 256'(nc));
          exp_q = ny;
          exp_f = nf;
          exp_c = nc;
        end
        ndone++;
      end else begin
        chk($sformatf("hs stable e%0d", e), q, exp_q);
      end
    end
    ena = 1'b0;
    chk("hs ndone", 256'(ndone), 256'(3));
    if (dpos.size() == 3) begin
      chk("hs d0", 256'(dpos[0]), 256'(9));
      chk("hs d1", 256'(dpos[1]), 256'(19));
      chk("hs d2", 256'(dpos[2]), 256'(29));
    end

    // reset during the 4th convert cycle
    @(negedge clk);
    nums = rand_vec(-1);
    ena  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid q", q, '0);
    chk("mid flags", 256'(sf), '0);
    chk("mid cnt", 256'(sc), '0);
    chk("mid busy", 256'(busy), '0);
    chk("mid done", 256'(done), '0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q = '0;
    exp_f = '0;
    exp_c = '0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("mid quiet", 256'(ndone), '0);
    run_vec(rand_vec(-1), "post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
